// File: rtl/lifo_arb.sv
// Round-robin arbiter that lets NUM_REQ requesters share one external LIFO,
// with a flush sequencer that drains the LIFO and reports completion.
module lifo_arb #(
   parameter int NUM_REQ = 4,
   parameter int DWIDTH  = 8,
   parameter int AWIDTH  = 4
) (
   input  logic                          clk_i,
   input  logic                          srst_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ-1:0]            req_pop_i,
   input  logic [NUM_REQ*DWIDTH-1:0]     req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic                          rsp_valid_o,
   output logic [$clog2(NUM_REQ)-1:0]    rsp_id_o,
   output logic [DWIDTH-1:0]             rsp_data_o,
   input  logic                          flush_i,
   output logic                          flush_done_o,
   output logic                          lifo_wrreq_o,
   output logic [DWIDTH-1:0]             lifo_data_o,
   output logic                          lifo_rdreq_o,
   input  logic [DWIDTH-1:0]             lifo_q_i,
   input  logic                          lifo_empty_i,
   input  logic                          lifo_full_i,
   input  logic [AWIDTH:0]               lifo_usedw_i
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam logic [AWIDTH:0] DEPTH = (AWIDTH+1)'(2**AWIDTH);

   typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_DONE} state_t;

   state_t             state_q, state_d;
   logic [IDW-1:0]     rr_ptr;
   logic [IDW-1:0]     grant_idx;
   logic               grant_found;
   logic               grant_active;
   logic               gnt_pop;
   logic [NUM_REQ-1:0] eligible;
   logic               rsp_pending_q;
   logic [IDW-1:0]     rsp_id_q;
   logic               lifo_empty;
   logic               lifo_full;

   // Either status source blocking an operation is enough to hold it off.
   assign lifo_empty = lifo_empty_i | (lifo_usedw_i == '0);
   assign lifo_full  = lifo_full_i  | (lifo_usedw_i == DEPTH);

   // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid_i[i] & (req_pop_i[i] ? !lifo_empty : !lifo_full);
      end
   end

   // Round-robin search beginning at rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      int idx;
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      for (int j = 0; j < NUM_REQ; j++) begin
         idx = int'(rr_ptr) + j;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!grant_found && eligible[IDW'(idx)]) begin
            grant_found = 1'b1;
            grant_idx   = IDW'(idx);
         end
      end
   end

   assign grant_active = grant_found && (state_q == ST_IDLE) && !srst_i;
   assign gnt_pop      = req_pop_i[grant_idx];

   assign req_ready_o  = grant_active ? (NUM_REQ'(1) << grant_idx) : '0;
   assign lifo_wrreq_o = grant_active & !gnt_pop;
   assign lifo_rdreq_o = (grant_active & gnt_pop)
                       | ((state_q == ST_FLUSH) & !srst_i & !lifo_empty);
   assign lifo_data_o  = req_data_i[grant_idx*DWIDTH +: DWIDTH];

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (flush_i)    state_d = ST_FLUSH;
         ST_FLUSH: if (lifo_empty) state_d = ST_DONE;
         ST_DONE:                  state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q       <= ST_IDLE;
         rr_ptr        <= '0;
         rsp_pending_q <= 1'b0;
         rsp_id_q      <= '0;
      end else begin
         state_q       <= state_d;
         rsp_pending_q <= grant_active & gnt_pop;
         if (grant_active) begin
            rr_ptr <= (grant_idx == IDW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            if (gnt_pop) rsp_id_q <= grant_idx;
         end
      end
   end

   // Outputs are masked while reset is held so an in-flight pop or DONE never leaks out.
   assign rsp_valid_o  = rsp_pending_q & !srst_i;
   assign rsp_id_o     = srst_i ? '0 : rsp_id_q;
   assign rsp_data_o   = lifo_q_i;
   assign flush_done_o = (state_q == ST_DONE) & !srst_i;

endmodule

// File: tb/tb_lifo_arb.sv
// Self-checking bench for lifo_arb: behavioural LIFO, reference arbiter model
// with a response scoreboard, a directed vector table and corner-case sequences.
module tb_lifo_arb;
   localparam int NR = 4;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int DEPTH = 16;

   logic              clk = 1'b0;
   logic              srst;
   logic [NR-1:0]     req_valid, req_pop, req_ready;
   logic [NR*DW-1:0]  req_data;
   logic              rsp_valid;
   logic [1:0]        rsp_id;
   logic [DW-1:0]     rsp_data;
   logic              flush, flush_done;
   logic              lifo_wrreq, lifo_rdreq;
   logic [DW-1:0]     lifo_data, lifo_q;
   logic              lifo_empty, lifo_full;
   logic [AW:0]       lifo_usedw;

   always #5 clk = ~clk;

   lifo_arb #(.NUM_REQ(NR), .DWIDTH(DW), .AWIDTH(AW)) dut (
      .clk_i(clk), .srst_i(srst),
      .req_valid_i(req_valid), .req_pop_i(req_pop), .req_data_i(req_data),
      .req_ready_o(req_ready),
      .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
      .flush_i(flush), .flush_done_o(flush_done),
      .lifo_wrreq_o(lifo_wrreq), .lifo_data_o(lifo_data), .lifo_rdreq_o(lifo_rdreq),
      .lifo_q_i(lifo_q), .lifo_empty_i(lifo_empty), .lifo_full_i(lifo_full),
      .lifo_usedw_i(lifo_usedw)
   );

   // Behavioural external LIFO: q is valid the cycle after rdreq.
   logic [DW-1:0] mem [DEPTH];
   int            cnt = 0;
   always @(posedge clk) begin
      if (srst) cnt <= 0;
      else if (lifo_wrreq && cnt < DEPTH) begin
         mem[cnt] <= lifo_data;
         cnt      <= cnt + 1;
      end else if (lifo_rdreq && cnt > 0) begin
         lifo_q <= mem[cnt-1];
         cnt    <= cnt - 1;
      end
   end
   assign lifo_empty = (cnt == 0);
   assign lifo_full  = (cnt == DEPTH);
   assign lifo_usedw = (AW+1)'(cnt);

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model of the arbiter and scoreboard of pending responses.
   typedef enum {M_IDLE, M_FLUSH, M_DONE} mstate_t;
   typedef struct { int id; logic [DW-1:0] data; } rsp_t;

   mstate_t       m_state = M_IDLE;
   int            m_rr = 0;
   logic [DW-1:0] m_stack[$];
   rsp_t          exp_q[$];
   logic [NR-1:0] seen_ready;

   // Called with inputs already driven; checks this cycle, updates model, advances one clock.
   task automatic cycle();
      logic [NR-1:0] e_ready;
      logic          e_wr, e_rd, e_done, e_rsp, m_empty, m_full;
      int            k;
      rsp_t          r;
      #1;
      m_empty = (m_stack.size() == 0);
      m_full  = (m_stack.size() == DEPTH);
      e_ready = '0; e_wr = 1'b0; e_rd = 1'b0; e_done = 1'b0; k = -1;
      e_rsp   = (exp_q.size() > 0) && !srst;
      if (!srst) begin
         if (m_state == M_IDLE) begin
            for (int j = 0; j < NR; j++) begin
               int i;
               i = (m_rr + j) % NR;
               if (k < 0 && req_valid[i] && (req_pop[i] ? !m_empty : !m_full)) k = i;
            end
            if (k >= 0) begin
               e_ready[k] = 1'b1;
               if (req_pop[k]) e_rd = 1'b1; else e_wr = 1'b1;
            end
         end else if (m_state == M_FLUSH) begin
            e_rd = !m_empty;
         end else begin
            e_done = 1'b1;
         end
      end
      seen_ready = req_ready;
      check("ready", req_ready, e_ready);
      check("wrreq", lifo_wrreq, e_wr);
      check("rdreq", lifo_rdreq, e_rd);
      check("wr_rd_exclusive", lifo_wrreq & lifo_rdreq, 0);
      check("flush_done", flush_done, e_done);
      check("rsp_valid", rsp_valid, e_rsp);
      check("usedw", lifo_usedw, m_stack.size());
      if (e_wr) check("push_data", lifo_data, req_data[k*DW +: DW]);
      if (srst) check("rsp_id_in_reset", rsp_id, 0);
      if (e_rsp) begin
         r = exp_q.pop_front();
         check("rsp_id", rsp_id, r.id);
         check("rsp_data", rsp_data, r.data);
      end
      if (srst) begin
         m_state = M_IDLE; m_rr = 0;
         m_stack.delete(); exp_q.delete();
      end else begin
         case (m_state)
            M_IDLE: begin
               if (k >= 0) begin
                  if (req_pop[k]) begin
                     r.id = k; r.data = m_stack[$];
                     exp_q.push_back(r);
                     void'(m_stack.pop_back());
                  end else begin
                     m_stack.push_back(req_data[k*DW +: DW]);
                  end
                  m_rr = (k + 1) % NR;
               end
               if (flush) m_state = M_FLUSH;
            end
            M_FLUSH: if (m_empty) m_state = M_DONE; else void'(m_stack.pop_back());
            default: m_state = M_IDLE;
         endcase
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      srst = 1'b1; req_valid = '0; req_pop = '0; flush = 1'b0;
      cycle(); cycle();
      srst = 1'b0;
   endtask

   typedef struct {
      logic [NR-1:0]    valid, pop;
      logic [NR*DW-1:0] data;
      logic [NR-1:0]    exp_ready;
      logic             exp_rsp_v;
      logic [1:0]       exp_id;
      logic [DW-1:0]    exp_data;
   } vec_t;

   initial begin
      vec_t tbl[$];
      int rd_cnt, done_cnt, done_at, grant_at;

      // LIFO ordering for requester 0, then pop-on-empty hold-off vs push.
      tbl.push_back('{4'b0001, 4'b0000, 32'h000000A1, 4'b0001, 1'b0, 2'd0, 8'h00});
      tbl.push_back('{4'b0001, 4'b0000, 32'h000000A2, 4'b0001, 1'b0, 2'd0, 8'h00});
      tbl.push_back('{4'b0001, 4'b0000, 32'h000000A3, 4'b0001, 1'b0, 2'd0, 8'h00});
      tbl.push_back('{4'b0001, 4'b0001, 32'h00000000, 4'b0001, 1'b0, 2'd0, 8'h00});
      tbl.push_back('{4'b0001, 4'b0001, 32'h00000000, 4'b0001, 1'b1, 2'd0, 8'hA3});
      tbl.push_back('{4'b0001, 4'b0001, 32'h00000000, 4'b0001, 1'b1, 2'd0, 8'hA2});
      tbl.push_back('{4'b0000, 4'b0000, 32'h00000000, 4'b0000, 1'b1, 2'd0, 8'hA1});
      tbl.push_back('{4'b0110, 4'b0100, 32'h00005500, 4'b0010, 1'b0, 2'd0, 8'h00});
      tbl.push_back('{4'b0100, 4'b0100, 32'h00000000, 4'b0100, 1'b0, 2'd0, 8'h00});
      tbl.push_back('{4'b0000, 4'b0000, 32'h00000000, 4'b0000, 1'b1, 2'd2, 8'h55});

      srst = 1'b1; req_valid = '0; req_pop = '0; req_data = '0; flush = 1'b0;
      @(posedge clk); #1;
      do_reset();

      foreach (tbl[n]) begin
         req_valid = tbl[n].valid; req_pop = tbl[n].pop; req_data = tbl[n].data;
         #1;
         check($sformatf("tbl%0d_ready", n), req_ready, tbl[n].exp_ready);
         check($sformatf("tbl%0d_rsp_v", n), rsp_valid, tbl[n].exp_rsp_v);
         if (tbl[n].exp_rsp_v) begin
            check($sformatf("tbl%0d_rsp_id", n), rsp_id, tbl[n].exp_id);
            check($sformatf("tbl%0d_rsp_data", n), rsp_data, tbl[n].exp_data);
         end
         cycle();
      end

      // All four push continuously: strict rotation until full, then held off.
      do_reset();
      req_valid = 4'b1111; req_pop = '0; req_data = 32'h44332211;
      for (int i = 0; i < DEPTH; i++) begin
         #1 check($sformatf("rot%0d", i), req_ready, 32'(1) << (i % NR));
         cycle();
      end
      for (int i = 0; i < 2; i++) begin
         #1 check("full_holdoff", req_ready, 0);
         cycle();
      end
      check("full_usedw", lifo_usedw, 16);

      // Flush of 5 words with a push arriving during the drain.
      do_reset();
      req_pop = '0;
      for (int i = 0; i < 5; i++) begin
         req_valid = 4'b0001; req_data = 32'(8'h10 + i);
         cycle();
      end
      req_valid = '0; flush = 1'b1;
      cycle();
      flush = 1'b0; req_valid = 4'b1000; req_data = 32'hC3000000;
      rd_cnt = 0; done_cnt = 0; done_at = -1; grant_at = -1;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (lifo_rdreq) rd_cnt++;
         if (flush_done) begin done_cnt++; done_at = c; end
         if (req_ready[3] && grant_at < 0) grant_at = c;
         cycle();
         if (seen_ready[3]) req_valid = '0;
      end
      check("flush5_rdreqs", rd_cnt, 5);
      check("flush5_done_pulses", done_cnt, 1);
      check("flush5_grant_after_done", grant_at, done_at + 1);
      check("flush5_usedw", lifo_usedw, 1);

      // Pop granted in the flush cycle still responds; flush of empty LIFO is one cycle.
      do_reset();
      req_valid = 4'b0010; req_pop = '0; req_data = 32'h00007700;
      cycle();
      req_valid = 4'b0100; req_pop = 4'b0100; flush = 1'b1;
      #1 check("flush_same_cycle_grant", req_ready, 4'b0100);
      cycle();
      req_valid = '0; flush = 1'b0;
      #1 check("flush_pop_rsp_v", rsp_valid, 1);
      check("flush_pop_rsp_data", rsp_data, 8'h77);
      cycle();
      #1 check("empty_flush_done", flush_done, 1);
      cycle();
      cycle();

      // Reset kills an in-flight pop response.
      req_valid = 4'b0001; req_pop = '0; req_data = 32'h12;
      cycle();
      req_pop = 4'b0001;
      cycle();
      req_valid = '0; srst = 1'b1;
      #1 check("reset_kills_rsp", rsp_valid, 0);
      cycle();
      srst = 1'b0;

      // Reset two cycles into a 10-word flush: no done pulse, pointer back to 0.
      do_reset();
      req_pop = '0;
      for (int i = 0; i < 10; i++) begin
         req_valid = 4'b0100; req_data = 32'(i) << 16;
         cycle();
      end
      req_valid = '0; flush = 1'b1;
      cycle();
      flush = 1'b0;
      cycle(); cycle();
      srst = 1'b1;
      done_cnt = 0;
      for (int c = 0; c < 2; c++) begin
         #1 if (flush_done) done_cnt++;
         cycle();
      end
      srst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1 if (flush_done) done_cnt++;
         cycle();
      end
      check("abort_no_done", done_cnt, 0);
      check("abort_usedw", lifo_usedw, 0);
      req_valid = 4'b1111; req_pop = '0;
      #1 check("abort_rr_zero", req_ready, 4'b0001);
      cycle();

      // Random mixed traffic; requests stay stable until granted.
      do_reset();
      seen_ready = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NR; i++) begin
            if (!req_valid[i] || seen_ready[i]) begin
               req_valid[i] = ($urandom_range(0, 2) != 0);
               req_pop[i]   = $urandom_range(0, 1);
               req_data[i*DW +: DW] = DW'($urandom);
            end
         end
         flush = ($urandom_range(0, 49) == 0);
         cycle();
      end
      req_valid = '0; flush = 1'b0;
      cycle(); cycle();
      check("final_scoreboard_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
